// File: rtl/rr_pkg.sv
// Shared rhythm-game definitions: sequencer state encoding and the beatmap
// geometry used by the beatmap ROMs, the sequencer and the renderer.
package rr_pkg;

  localparam int unsigned RR_LANES      = 8;  // note lanes per beatmap row
  localparam int unsigned RR_BEATMAP_AW = 3;  // beatmap ROM address width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/beat_tick_gen.sv
// Tempo divider: counts 0..TICKS_PER_BEAT-1 while enabled, holds otherwise.
// Ports: clk, resetn (sync, active-low), clear (restart count at 0),
//        enable (advance count), tick (high on the count = TICKS_PER_BEAT-1 cycle).
module beat_tick_gen #(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_BEAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and beat strobe
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST_CNT) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: fetches one beatmap row per beat into a note highway and
// presents the row reaching the hit line through a valid/ready handshake.
// Ports: clk, resetn (sync, active-low); start/pause control; rom_addr/rom_data
//        to the combinational beatmap ROM; hit_row/beat_idx/beat_valid/beat_ready
//        hit-line handshake; playing/done state decode; overrun sticky flag.
module beat_sequencer
  import rr_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned NUM_BEATS      = 8,
  parameter int unsigned ADDR_W         = RR_BEATMAP_AW,
  parameter int unsigned LANES          = RR_LANES,
  parameter int unsigned HIGHWAY_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LANES-1:0]  rom_data,
  output logic [LANES-1:0]  hit_row,
  output logic [ADDR_W-1:0] beat_idx,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

  // Last beat that presents a row at the hit line; the beat counter parks here.
  localparam int unsigned LAST_BEAT = NUM_BEATS + HIGHWAY_DEPTH - 1;
  localparam int unsigned K_W       = $clog2(LAST_BEAT + 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] fp_q, fp_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [K_W-1:0]    bcnt_q, bcnt_d;
  logic [LANES-1:0]  hw_q [HIGHWAY_DEPTH];
  logic [LANES-1:0]  hw_d [HIGHWAY_DEPTH];
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic restart, tick, beat, at_hit, xfer, final_xfer;

  assign restart    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Ticks past the last valid beat are dropped so a pending row stays put.
  assign beat       = tick && (bcnt_q < K_W'(LAST_BEAT));
  // Current beat k = bcnt_q + 1 reaches the hit line once k >= HIGHWAY_DEPTH.
  assign at_hit     = bcnt_q >= K_W'(HIGHWAY_DEPTH - 1);
  assign xfer       = valid_q && beat_ready;
  assign final_xfer = xfer && (idx_q == ADDR_W'(NUM_BEATS - 1));

  beat_tick_gen #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .clear (restart),
    .enable(state_q == ST_PLAY),
    .tick  (tick)
  );

  // Play-state transitions; the final handshake wins over pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PLAY;
      ST_PLAY:  if (final_xfer) state_d = ST_DONE;
                else if (pause) state_d = ST_PAUSE;
      ST_PAUSE: if (final_xfer) state_d = ST_DONE;
                else if (!pause) state_d = ST_PLAY;
      ST_DONE:  if (start) state_d = ST_PLAY;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Highway shift, fetch pointer and hit-line handshake.
  always_comb begin
    fp_d    = fp_q;
    bcnt_d  = bcnt_q;
    hw_d    = hw_q;
    idx_d   = idx_q;
    valid_d = valid_q && !beat_ready;
    ovr_d   = ovr_q;
    if (restart) begin
      fp_d    = '0;
      bcnt_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      for (int i = 0; i < int'(HIGHWAY_DEPTH); i++) hw_d[i] = '0;
    end else if (beat) begin
      bcnt_d = bcnt_q + K_W'(1);
      if (fp_q != ADDR_W'(NUM_BEATS - 1)) fp_d = fp_q + ADDR_W'(1);
      for (int i = int'(HIGHWAY_DEPTH) - 1; i > 0; i--) hw_d[i] = hw_q[i-1];
      hw_d[0] = (bcnt_q < K_W'(NUM_BEATS)) ? rom_data : '0;
      if (at_hit) begin
        valid_d = 1'b1;
        idx_d   = ADDR_W'(bcnt_q - K_W'(HIGHWAY_DEPTH - 1));
        // An unaccepted row is being replaced.
        if (valid_q && !beat_ready) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      fp_q    <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < int'(HIGHWAY_DEPTH); i++) hw_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < int'(HIGHWAY_DEPTH); i++) hw_q[i] <= hw_d[i];
    end
  end

  assign rom_addr   = fp_q;
  assign hit_row    = hw_q[HIGHWAY_DEPTH-1];
  assign beat_idx   = idx_q;
  assign beat_valid = valid_q;
  assign overrun    = ovr_q;
  assign playing    = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with a 4-tick beat and 4-row highway.
module tb_beat_sequencer;

  localparam int unsigned TPB = 4;
  localparam int unsigned NB  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned LN  = 8;
  localparam int unsigned HD  = 4;

  typedef struct packed {
    logic [7:0] row;
    logic [2:0] idx;
  } beat_vec_t;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          pause;
  logic [AW-1:0] rom_addr;
  logic [LN-1:0] rom_data;
  logic [LN-1:0] hit_row;
  logic [AW-1:0] beat_idx;
  logic          beat_valid;
  logic          beat_ready;
  logic          playing;
  logic          done;
  logic          overrun;

  logic [7:0] level [NB] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};
  beat_vec_t  exp_tab [NB];

  int cyc     = 0;
  int s_cyc   = 0;
  int n_pass  = 0;
  int n_total = 0;

  beat_sequencer #(
    .TICKS_PER_BEAT(TPB),
    .NUM_BEATS     (NB),
    .ADDR_W        (AW),
    .LANES         (LN),
    .HIGHWAY_DEPTH (HD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .pause     (pause),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .hit_row   (hit_row),
    .beat_idx  (beat_idx),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .playing   (playing),
    .done      (done),
    .overrun   (overrun)
  );

  always_comb rom_data = level[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".rom_addr"},   32'(rom_addr),   32'd0);
    chk({tag, ".hit_row"},    32'(hit_row),    32'd0);
    chk({tag, ".beat_idx"},   32'(beat_idx),   32'd0);
    chk({tag, ".beat_valid"}, 32'(beat_valid), 32'd0);
    chk({tag, ".playing"},    32'(playing),    32'd0);
    chk({tag, ".done"},       32'(done),       32'd0);
    chk({tag, ".overrun"},    32'(overrun),    32'd0);
  endtask

  // One-cycle start pulse; the cycle count is referenced to its edge.
  task automatic start_play();
    start = 1'b1;
    step();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // Wait for each presented beat, check it against the table, then accept it.
  task automatic play_beats(input int first, input int last, input int extra, input bit rnd);
    int n;
    for (int j = first; j <= last; j++) begin
      n = 0;
      while (!beat_valid && n < 40) begin
        step();
        n++;
      end
      chk("valid_rise", 32'(beat_valid), 32'd1);
      chk("hit_row",    32'(hit_row),    32'(exp_tab[j].row));
      chk("beat_idx",   32'(beat_idx),   32'(exp_tab[j].idx));
      chk("beat_time",  32'(cyc - s_cyc), 32'(HD * TPB + TPB * j + extra));
      n = 0;
      while (beat_valid && n < 8) begin
        beat_ready = rnd ? ((n >= 2) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
        step();
        n++;
      end
      chk("valid_drop", 32'(beat_valid), 32'd0);
    end
  endtask

  initial begin
    exp_tab[0] = '{row: 8'h3C, idx: 3'd0};
    exp_tab[1] = '{row: 8'h7E, idx: 3'd1};
    exp_tab[2] = '{row: 8'hFF, idx: 3'd2};
    exp_tab[3] = '{row: 8'hFF, idx: 3'd3};
    exp_tab[4] = '{row: 8'hFF, idx: 3'd4};
    exp_tab[5] = '{row: 8'hFF, idx: 3'd5};
    exp_tab[6] = '{row: 8'h7E, idx: 3'd6};
    exp_tab[7] = '{row: 8'h3C, idx: 3'd7};

    resetn     = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    beat_ready = 1'b0;
    steps(2);
    resetn = 1'b1;
    reset_checks("reset");

    // Full level with the renderer always ready.
    beat_ready = 1'b1;
    start_play();
    chk("t1.playing", 32'(playing), 32'd1);
    play_beats(0, 7, 0, 1'b0);
    chk("t1.done",    32'(done),    32'd1);
    chk("t1.playing", 32'(playing), 32'd0);
    chk("t1.overrun", 32'(overrun), 32'd0);

    // Restart from DONE, stall across beats 4 and 5.
    beat_ready = 1'b0;
    start_play();
    chk("t2.done",    32'(done),    32'd0);
    chk("t2.playing", 32'(playing), 32'd1);
    steps(16);
    chk("t2.b4_valid", 32'(beat_valid), 32'd1);
    chk("t2.b4_row",   32'(hit_row),    32'h3C);
    chk("t2.b4_ovr",   32'(overrun),    32'd0);
    steps(3);
    chk("t2.hold_row", 32'(hit_row),    32'h3C);
    chk("t2.hold_idx", 32'(beat_idx),   32'd0);
    step();
    chk("t2.b5_valid", 32'(beat_valid), 32'd1);
    chk("t2.b5_row",   32'(hit_row),    32'h7E);
    chk("t2.b5_idx",   32'(beat_idx),   32'd1);
    chk("t2.b5_ovr",   32'(overrun),    32'd1);
    beat_ready = 1'b1;
    play_beats(1, 7, 0, 1'b0);
    chk("t2.done",     32'(done),    32'd1);
    chk("t2.ovr_keep", 32'(overrun), 32'd1);

    // Start in DONE clears overrun and replays cleanly.
    start_play();
    chk("t5.ovr_clr", 32'(overrun), 32'd0);
    chk("t5.done",    32'(done),    32'd0);
    play_beats(0, 7, 0, 1'b0);
    chk("t5.done",    32'(done),    32'd1);
    chk("t5.overrun", 32'(overrun), 32'd0);

    // Reset landing on beat 6 with an overrun pending.
    beat_ready = 1'b0;
    start_play();
    steps(23);
    chk("t4.pre_ovr",  32'(overrun),  32'd1);
    chk("t4.pre_addr", 32'(rom_addr), 32'd5);
    resetn = 1'b0;
    step();
    reset_checks("t4");
    resetn = 1'b1;

    // Replay after reset; a start pulse mid-play is ignored; then a 10-cycle pause.
    beat_ready = 1'b1;
    start_play();
    steps(5);
    start = 1'b1;
    step();
    start = 1'b0;
    play_beats(0, 1, 0, 1'b0);
    step();
    pause = 1'b1;
    steps(10);
    chk("t3.playing", 32'(playing),    32'd1);
    chk("t3.valid",   32'(beat_valid), 32'd0);
    chk("t3.row",     32'(hit_row),    32'h7E);
    chk("t3.idx",     32'(beat_idx),   32'd1);
    pause = 1'b0;
    play_beats(2, 7, 10, 1'b0);
    chk("t3.done", 32'(done), 32'd1);

    // Randomly toggling ready, each beat still accepted before the next.
    beat_ready = 1'b0;
    start_play();
    play_beats(0, 7, 0, 1'b1);
    chk("t6.done",    32'(done),    32'd1);
    chk("t6.overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Drives the beatmap ROM and turns its per-beat lane rows into a timed note stream for the renderer and hit-judging logic. A tempo divider fetches one beatmap row per beat and pushes it into a `HIGHWAY_DEPTH`-deep shift buffer, the note highway. The row leaving the bottom of the highway is presented at the hit line through a valid/ready handshake. Sits between the beatmap ROM (upstream, combinational) and the VGA renderer/score logic (downstream).

## Interface
- `TICKS_PER_BEAT`, 12_500_000: clock cycles per beat (4 beats/s at 50 MHz); must be ≥ 2.
- `NUM_BEATS`, 8: number of beatmap rows in the level.
- `ADDR_W`, 3: beatmap address width; `NUM_BEATS` ≤ 2^`ADDR_W`.
- `LANES`, 8: note lanes per row (beatmap data width).
- `HIGHWAY_DEPTH`, 4: rows between fetch and hit line; ≥ 1.

Ports:
- `clk`  in  1  single clock for the block.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; begins play from IDLE or DONE.
- `pause`  in  1  level; freezes play while high.
- `rom_addr`  out  `ADDR_W`  beatmap address.
- `rom_data`  in  `LANES`  beatmap row; combinational from `rom_addr`.
- `hit_row`  out  `LANES`  row at hit line.
- `beat_idx`  out  `ADDR_W`  beatmap index of `hit_row`.
- `beat_valid`  out  1  `hit_row`/`beat_idx` valid.
- `beat_ready`  in  1  downstream accepts.
- `playing`  out  1  high in PLAY or PAUSE.
- `done`  out  1  high in DONE.
- `overrun`  out  1  sticky; a beat was overwritten before acceptance.

## Operation
- States: IDLE, PLAY, PAUSE, DONE.
  - IDLE→PLAY on `start`.
  - PLAY→PAUSE while `pause`=1.
  - PAUSE→PLAY when `pause`=0.
  - PLAY→DONE after the final beat's handshake completes.
  - DONE→PLAY on `start`.
- `start` is ignored in PLAY and PAUSE. In IDLE or DONE, `pause` is ignored.
- Entering PLAY from IDLE or DONE clears the tick counter, fetch pointer, beat counter, highway and `overrun`.
- Tick: in PLAY, the counter counts 0..`TICKS_PER_BEAT`-1. The cycle with count = `TICKS_PER_BEAT`-1 is a beat; the counter then returns to 0. In PAUSE the counter holds.
- On beat k (1-based):
  - highway[0] ← `rom_data` if k ≤ `NUM_BEATS`, else 0.
  - highway[i] ← highway[i-1].
  - Fetch pointer increments, saturating at `NUM_BEATS`-1.
  - `rom_addr` = fetch pointer.
- Hit line: `hit_row` = highway[`HIGHWAY_DEPTH`-1].
  - For k ≥ `HIGHWAY_DEPTH`, `beat_valid` rises with `beat_idx` = k-`HIGHWAY_DEPTH`.
  - Lead-in beats (k < `HIGHWAY_DEPTH`) never assert `beat_valid`.
- Handshake: a transfer occurs when `beat_valid` & `beat_ready` are both high. `beat_valid` then drops the next cycle unless a new beat occurs that same cycle. `hit_row` and `beat_idx` are stable while `beat_valid` is high and unaccepted.
- Overrun: if a beat occurs while `beat_valid` is high and `beat_ready` is low, the new row replaces the old one, `beat_valid` stays high, and `overrun` sets until the next start or reset.
- Completion: the last valid beat is k = `NUM_BEATS`+`HIGHWAY_DEPTH`-1. DONE is entered the cycle after that beat is accepted. `pause` has no effect on a pending handshake.

## Timing
- Reset (`resetn`=0 at a clock edge) has priority over all other inputs, including mid-play. Outputs next cycle: state IDLE, `rom_addr`=0, `hit_row`=0, `beat_idx`=0, `beat_valid`=0, `playing`=0, `done`=0, `overrun`=0.
- First beat: `TICKS_PER_BEAT` cycles after the `start` edge.
- Registered outputs update the cycle after the beat cycle.
- `rom_data` is sampled on the beat cycle itself; the ROM is combinational, so zero latency.
- Fetch-to-hit latency: `HIGHWAY_DEPTH`-1 beats.
- All outputs are registered except `playing` and `done`, which decode the state register.

## Structure
- Shared package `rr_pkg`:
  - state enum `seq_state_t`.
  - constants `RR_LANES`=8 and `RR_BEATMAP_AW`=3, shared with the beatmap ROMs and renderer.
- One sub-module, `beat_tick_gen`: the tempo divider. Inputs: `clk`, `resetn`, `clear`, `enable`; output: one-cycle `tick`; parameter `TICKS_PER_BEAT`.

## Test plan
Bench parameters: `TICKS_PER_BEAT`=4, `HIGHWAY_DEPTH`=4, level-1 beatmap rows 3C,7E,FF,FF,FF,FF,7E,3C.

1. Reset, then `start`, `beat_ready`=1 → first `beat_valid` at beat 4 with `hit_row`=3C, `beat_idx`=0. Eight handshakes follow, rows 3C,7E,FF,FF,FF,FF,7E,3C, `beat_idx` 0..7. `done`=1 after beat 11; `overrun`=0.
2. `beat_ready`=0 across beats 4 and 5 → `hit_row`=7E, `beat_idx`=1, `overrun`=1. Raising `beat_ready` completes one transfer.
3. `pause` high for 10 cycles mid-play → the tick counter holds and beat spacing stretches by exactly 10 cycles. `hit_row` stays unchanged and the remaining sequence is intact.
4. `resetn` low during beat 6 → next cycle all outputs are at reset values. A subsequent `start` replays from `beat_idx`=0.
5. `start` pulsed during PLAY → ignored. `start` in DONE → clean replay with `overrun` cleared.
6. `beat_ready` toggling randomly, each beat accepted before the next → every row is delivered exactly once, in order, with `overrun`=0.
